// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
// Shared definitions for the PS/2 host-to-device transmitter:
//   - state_t          : transmitter FSM states
//   - *_DEF            : default cycle counts at a 16 MHz system clock
//   - TIMER_W          : width of the shared inhibit/timeout timer
//   - PS2_CMD_*        : keyboard command bytes issued by the host
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        PARITY,
        STOP,
        ACK,
        LINEWAIT
    } state_t;

    localparam int INHIBIT_CYC_DEF  = 1600;    // 100 us clock-low hold
    localparam int START_TO_CYC_DEF = 240000;  // 15 ms wait for first device clock
    localparam int XFER_TO_CYC_DEF  = 32000;   // 2 ms first fall to end of ACK
    localparam int FILT_LEN_DEF     = 4;       // equal samples before filtered level moves

    localparam int TIMER_W = 18;

    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Conditions one raw PS/2 pin: 2-FF synchronizer followed by a FILT_LEN-sample
// agreement filter. The filtered level only changes after the synchronized pin
// has disagreed with it for FILT_LEN consecutive cycles, so single-cycle
// glitches never reach the FSM.
// Ports:
//   clk    in  : system clock
//   reset  in  : asynchronous active-high reset (lines idle high)
//   pin    in  : raw, asynchronous pin level
//   level  out : filtered line level
//   fall   out : one-cycle strobe, high the first cycle level reads 0 after 1
module ps2_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            cnt    <= '0;
            level  <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
            fall   <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
                level <= sync_b;
                cnt   <= '0;
                fall  <= ~sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the bus, requests to send, then
// shifts out 8 data bits LSB first, odd parity and stop on the device's clock
// falls, and waits for the ACK and idle bus. Lines are driven only through
// active-low output enables (1 = pull low).
// Optional build macro:
//   PS2TX_ACK_CHECK_EN : a high data line at the ACK fall ends the frame in
//                        tx_error instead of tx_done.
// Ports:
//   clk        in  : 16 MHz system clock
//   reset      in  : asynchronous active-high reset
//   tx_data    in  : command byte, captured on tx_valid && tx_ready
//   tx_valid   in  : request to send
//   tx_ready   out : high in IDLE only
//   tx_done    out : one-cycle pulse, frame acknowledged
//   tx_error   out : one-cycle pulse, timeout or missing ACK
//   rx_inhibit out : high while the transmitter owns the bus
//   ps2clk_in  in  : raw PS/2 clock pin
//   ps2dat_in  in  : raw PS/2 data pin
//   ps2clk_oe  out : 1 pulls the clock line low
//   ps2dat_oe  out : 1 pulls the data line low
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYC  = INHIBIT_CYC_DEF,
    parameter int START_TO_CYC = START_TO_CYC_DEF,
    parameter int XFER_TO_CYC  = XFER_TO_CYC_DEF,
    parameter int FILT_LEN     = FILT_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    input  logic       ps2clk_in,
    input  logic       ps2dat_in,
    output logic       ps2clk_oe,
    output logic       ps2dat_oe
);

    localparam logic [TIMER_W-1:0] INHIBIT_LIM = TIMER_W'(INHIBIT_CYC - 1);
    localparam logic [TIMER_W-1:0] START_LIM   = TIMER_W'(START_TO_CYC);
    localparam logic [TIMER_W-1:0] XFER_LIM    = TIMER_W'(XFER_TO_CYC);

    logic fclk, fclk_fall, fdat, unused_fdat_fall;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk(clk), .reset(reset), .pin(ps2clk_in), .level(fclk), .fall(fclk_fall)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
        .clk(clk), .reset(reset), .pin(ps2dat_in), .level(fdat), .fall(unused_fdat_fall)
    );

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic               last_q, last_d;     // bit 7 already on the line
    logic [7:0]         shreg_q, shreg_d;
    logic               par_q, par_d;
    logic               clk_oe_q, clk_oe_d;
    logic               dat_oe_q, dat_oe_d;
    logic               expire, done, err;
`ifdef PS2TX_ACK_CHECK_EN
    logic               ack_q, ack_d;       // filtered data at the ACK fall
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done     = 1'b0;
        err      = 1'b0;
        expire   = 1'b0;
`ifdef PS2TX_ACK_CHECK_EN
        ack_d    = ack_q;
`endif

        // The timer is reloaded at the first fall and then runs untouched
        // until the frame leaves LINEWAIT.
        if (state_q == START) begin
            expire = (timer_q >= START_LIM);
        end else if (state_q inside {DATA, PARITY, STOP, ACK, LINEWAIT}) begin
            expire = (timer_q >= XFER_LIM);
        end

        if (expire) begin
            state_d  = IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            err      = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    if (tx_valid) begin
                        state_d  = INHIBIT;
                        shreg_d  = tx_data;
                        par_d    = ~^tx_data;
                        timer_d  = '0;
                        clk_oe_d = 1'b1;
                    end
                end
                // Device clock falls here are our own pull-down or contention;
                // both are ignored while the clock stays forced low.
                INHIBIT: begin
                    if (timer_q >= INHIBIT_LIM) begin
                        state_d  = START;
                        timer_d  = '0;
                        clk_oe_d = 1'b0;
                        dat_oe_d = 1'b1;
                    end
                end
                START: begin
                    if (fclk_fall) begin
                        state_d  = DATA;
                        dat_oe_d = ~shreg_q[0];
                        bitcnt_d = 3'd1;
                        last_d   = 1'b0;
                        timer_d  = '0;
                    end
                end
                DATA: begin
                    if (fclk_fall) begin
                        if (last_q) begin
                            state_d  = PARITY;
                            dat_oe_d = ~par_q;
                        end else begin
                            shreg_d  = {1'b0, shreg_q[7:1]};
                            dat_oe_d = ~shreg_q[1];
                            if (bitcnt_q == 3'd7) begin
                                last_d = 1'b1;
                            end else begin
                                bitcnt_d = bitcnt_q + 3'd1;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (fclk_fall) begin
                        state_d  = STOP;
                        dat_oe_d = 1'b0;
                    end
                end
                STOP: begin
                    if (fclk_fall) begin
                        state_d = ACK;
`ifdef PS2TX_ACK_CHECK_EN
                        ack_d   = fdat;
`endif
                    end
                end
                ACK: begin
                    if (fclk) begin
                        state_d = LINEWAIT;
                    end
                end
                LINEWAIT: begin
                    if (fclk && fdat) begin
                        state_d = IDLE;
`ifdef PS2TX_ACK_CHECK_EN
                        err     = ack_q;
                        done    = ~ack_q;
`else
                        done    = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Async clear of the OE flops releases both lines as soon as reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            last_q   <= 1'b0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

`ifdef PS2TX_ACK_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end
`endif

    // Gating with expire drops both lines in the same cycle tx_error pulses.
    assign ps2clk_oe  = clk_oe_q & ~expire;
    assign ps2dat_oe  = dat_oe_q & ~expire;
    assign tx_ready   = (state_q == IDLE);
    assign rx_inhibit = (state_q != IDLE);
    assign tx_done    = done;
    assign tx_error   = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Drives command frames into ps2_host_tx against a PS/2 device model clocking
// at 12.5 kHz (640-cycle half period at 16 MHz). Expected frame outcomes are
// queued at accept time; a monitor pops them whenever tx_done/tx_error pulses.
// The start timeout is shortened to keep the run short.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH      = 1600;
    localparam int START_TO = 8000;
    localparam int XFER_TO  = 32000;
    localparam int FILT     = 4;
    localparam int HALF     = 640;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, rx_inhibit;
    logic       ps2clk_in, ps2dat_in, ps2clk_oe, ps2dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic [9:0] dev_bits = '0;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         accept_cyc = 0;
    int         pulse_cyc = 0;
    int         n_done = 0;
    int         n_err = 0;
    int         n_pass = 0;
    int         n_total = 0;

    // Open-collector bus with pull-ups.
    assign ps2clk_in = ~(ps2clk_oe | dev_clk_low);
    assign ps2dat_in = ~(ps2dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYC(INH), .START_TO_CYC(START_TO), .XFER_TO_CYC(XFER_TO), .FILT_LEN(FILT)
    ) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error),
        .rx_inhibit(rx_inhibit), .ps2clk_in(ps2clk_in), .ps2dat_in(ps2dat_in),
        .ps2clk_oe(ps2clk_oe), .ps2dat_oe(ps2dat_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every output pulse must match the oldest queued frame.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_done || tx_error) begin
                pulse_cyc = cyc;
                if (tx_done)  n_done++;
                if (tx_error) n_err++;
                check("pulse_exclusive", 32'(tx_done & tx_error), 0);
                check("ready_low_at_pulse", 32'(tx_ready), 0);
                check("pulse_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("pulse_is_error", 32'(tx_error), 32'(mon_e.is_err));
                    if (mon_e.is_err) begin
                        check("err_clk_oe_released", 32'(ps2clk_oe), 0);
                        check("err_dat_oe_released", 32'(ps2dat_oe), 0);
                    end else begin
                        check("rx_byte", 32'(dev_bits[7:0]), 32'(mon_e.data));
                        check("rx_parity", 32'(dev_bits[8]), 32'(mon_e.par));
                        check("rx_stop", 32'(dev_bits[9]), 1);
                    end
                end
                @(negedge clk);
                check("ready_after_pulse", 32'(tx_ready), 1);
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit push, input logic is_err,
                        input logic [7:0] edata, input logic epar);
        exp_t e;
        @(posedge clk); #1;
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid   = 1'b0;
        accept_cyc = cyc;
        e.is_err = is_err;
        e.data   = edata;
        e.par    = epar;
        if (push) exp_q.push_back(e);
        check("clk_oe_after_accept", 32'(ps2clk_oe), 1);
        check("ready_drop", 32'(tx_ready), 0);
        check("rx_inhibit_busy", 32'(rx_inhibit), 1);
    endtask

    // mode 0: normal with ACK, 1: never clocks, 2: withholds ACK.
    // glitch_bit / reset_bit select the clock period for the event (0 = none).
    task automatic device(input int mode, input int glitch_bit, input int reset_bit);
        int n;
        dev_bits = '0;
        n = 0;
        while (ps2clk_oe && n < INH + 100) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_hold_min", 32'(n >= INH), 1);
        check("inhibit_hold_max", 32'(n <= INH + 2), 1);
        check("start_bit_low", 32'(ps2dat_in), 0);
        if (mode == 1) return;
        repeat (50) @(posedge clk);
        for (int i = 1; i <= 11; i++) begin
            #1 dev_clk_low = 1'b1;
            if (i == reset_bit) begin
                repeat (100) @(posedge clk);
                check("pre_reset_dat_oe", 32'(ps2dat_oe), 1);
                @(negedge clk);
                #2 reset = 1'b1;
                #1;
                check("reset_clk_oe", 32'(ps2clk_oe), 0);
                check("reset_dat_oe", 32'(ps2dat_oe), 0);
                check("reset_ready", 32'(tx_ready), 1);
                check("reset_rx_inhibit", 32'(rx_inhibit), 0);
                check("reset_no_pulse", 32'({tx_done, tx_error}), 0);
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                repeat (3) @(posedge clk);
                #1 reset = 1'b0;
                repeat (20) @(posedge clk);
                return;
            end
            repeat (HALF) @(posedge clk);
            #1 dev_clk_low = 1'b0;
            if (i <= 10) dev_bits[i-1] = ps2dat_in;
            if (i == 11) dev_dat_low = 1'b0;
            repeat (HALF / 2) @(posedge clk);
            if (i == glitch_bit) begin
                #1 dev_clk_low = 1'b1;
                @(posedge clk);
                #1 dev_clk_low = 1'b0;
            end
            if (i == 10 && mode == 0) dev_dat_low = 1'b1;
            repeat (HALF / 2) @(posedge clk);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!tx_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_finished", 32'(tx_ready), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #(1_200_000);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, lat;

        // Reset values, both during and after reset.
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2clk_oe), 0);
        check("rst_dat_oe", 32'(ps2dat_oe), 0);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_pulses", 32'({tx_done, tx_error}), 0);
        check("rst_rx_inhibit", 32'(rx_inhibit), 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_ready", 32'(tx_ready), 1);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1.
        d0 = n_done; e0 = n_err;
        send(PS2_CMD_LEDS, 1'b1, 1'b0, 8'hED, 1'b1);
        device(0, 0, 0);
        wait_idle(2000);
        check("leds_done_count", 32'(n_done - d0), 1);
        check("leds_err_count", 32'(n_err - e0), 0);

        // 0xF4: bits 0,0,1,0,1,1,1,1, parity 0, with tx_valid held mid-frame.
        d0 = n_done; e0 = n_err;
        send(PS2_CMD_ENABLE, 1'b1, 1'b0, 8'hF4, 1'b0);
        fork
            device(0, 0, 0);
            begin
                repeat (3000) @(posedge clk);
                #1 tx_data = 8'h00;
                tx_valid = 1'b1;
                repeat (8000) @(posedge clk);
                #1 tx_valid = 1'b0;
            end
        join
        wait_idle(2000);
        check("enable_done_count", 32'(n_done - d0), 1);
        check("enable_err_count", 32'(n_err - e0), 0);
        repeat (20) @(negedge clk);
        check("no_queued_frame_oe", 32'(ps2clk_oe), 0);
        check("no_queued_frame_ready", 32'(tx_ready), 1);

        // Device never clocks: error after inhibit + start timeout.
        d0 = n_done; e0 = n_err;
        send(PS2_CMD_RESET, 1'b1, 1'b1, 8'h00, 1'b0);
        device(1, 0, 0);
        wait_idle(START_TO + 500);
        lat = pulse_cyc - accept_cyc;
        check("timeout_latency_min", 32'(lat >= INH + START_TO - (FILT + 2)), 1);
        check("timeout_latency_max", 32'(lat <= INH + START_TO + (FILT + 2)), 1);
        check("timeout_err_count", 32'(n_err - e0), 1);
        check("timeout_done_count", 32'(n_done - d0), 0);
        check("timeout_clk_oe", 32'(ps2clk_oe), 0);
        check("timeout_dat_oe", 32'(ps2dat_oe), 0);

        // Device withholds the ACK.
        d0 = n_done; e0 = n_err;
`ifdef PS2TX_ACK_CHECK_EN
        send(PS2_CMD_ENABLE, 1'b1, 1'b1, 8'hF4, 1'b0);
        device(2, 0, 0);
        wait_idle(2000);
        check("noack_err_count", 32'(n_err - e0), 1);
        check("noack_done_count", 32'(n_done - d0), 0);
`else
        send(PS2_CMD_ENABLE, 1'b1, 1'b0, 8'hF4, 1'b0);
        device(2, 0, 0);
        wait_idle(2000);
        check("noack_done_count", 32'(n_done - d0), 1);
        check("noack_err_count", 32'(n_err - e0), 0);
`endif

        // Reset during bit 4 of a 0xED frame: no pulse, lines released.
        d0 = n_done; e0 = n_err;
        send(PS2_CMD_LEDS, 1'b0, 1'b0, 8'h00, 1'b0);
        device(0, 0, 5);
        check("reset_frame_no_pulse", 32'((n_done - d0) + (n_err - e0)), 0);
        check("reset_frame_ready", 32'(tx_ready), 1);

        // 0xFF after reset, with a one-cycle clock glitch during DATA.
        d0 = n_done; e0 = n_err;
        send(PS2_CMD_RESET, 1'b1, 1'b0, 8'hFF, 1'b1);
        device(0, 4, 0);
        wait_idle(2000);
        check("reset_cmd_done_count", 32'(n_done - d0), 1);
        check("reset_cmd_err_count", 32'(n_err - e0), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
